pipeline_mw_skid: RTL and testbench
===================================

// Module: pipeline_mw_skid
// PURPOSE
//   Parametrised MEM->WB pipeline stage with valid/ready handshake, flush and optional
//   2-entry skid buffer. Sits between the memory stage and the register-file write-back
//   mux; lets writeback stall (e.g. register-file port conflict) without a combinational
//   ready path back into memory, and suppresses register writes for bubbles and x0.
// PARAMETERS
//   DATA_WIDTH     32  width of ALU result, load data and PC+4
//   RD_WIDTH        5  destination register index width
//   RSRC_WIDTH      2  ResultSrc select width
//   SKID_EN         1  1: registered ready with 2-entry skid; 0: single register, ready = ready_w | ~valid_w
// PORTS
//   clk          in   1           rising-edge clock
//   rst          in   1           asynchronous active-high reset
//   flush        in   1           synchronous: drop all held entries and this cycle's input
//   valid_m      in   1           M-side payload valid
//   ready_m      out  1           stage can accept payload this cycle
//   RegWriteM    in   1           M-side register write enable
//   ResultSrcM   in   RSRC_WIDTH  M-side writeback source select
//   ALUResultM   in   DATA_WIDTH  M-side ALU result
//   rd           in   DATA_WIDTH  data-memory read data
//   RdM          in   RD_WIDTH    M-side destination register
//   PCPlus4M     in   DATA_WIDTH  M-side PC+4
//   valid_w      out  1           W-side payload valid
//   ready_w      in   1           writeback consumes payload this cycle
//   RegWriteW    out  1           qualified write enable: held RegWrite & valid_w & (RdW != 0)
//   ResultSrcW   out  RSRC_WIDTH  W-side writeback source select
//   ALUResultW   out  DATA_WIDTH  W-side ALU result
//   ReadDataW    out  DATA_WIDTH  W-side load data
//   RdW          out  RD_WIDTH    W-side destination register
//   PCPlus4W     out  DATA_WIDTH  W-side PC+4
// BEHAVIOUR
//   - Reset (async, any time incl. mid-stall): valid_w=0, all payload outputs 0, skid empty;
//     ready_m=1 while and after rst asserted. Held payloads are lost.
//   - Accept = valid_m & ready_m & ~flush. Consume = valid_w & ready_w. Latency: accepted
//     payload appears on W outputs the next cycle if output reg free. Order strictly FIFO.
//   - SKID_EN=1, states (skid_valid,valid_w):
//       EMPTY(0,0): accept -> FULL (load output reg).
//       FULL (0,1): accept&consume -> FULL (reload output); accept&~consume -> SKID (load skid);
//                   ~accept&consume -> EMPTY; else hold.
//       SKID (1,1): ready_m=0; consume -> FULL (skid moves to output reg); else hold.
//     ready_m = ~skid_valid, driven from a flop (no comb path from ready_w).
//   - SKID_EN=0: single output reg; ready_m = ready_w | ~valid_w (combinational);
//     accept loads output reg, consume without accept -> valid_w=0.
//   - flush: next cycle valid_w=0, skid empty, input dropped regardless of valid_m; flush
//     overrides accept and consume; payload regs may keep stale data but RegWriteW=0.
//   - RegWriteW is 0 whenever valid_w=0 or RdW==0 (x0 writes never reach register file).
//   - Payload regs load only on accept/skid transfer; stalled outputs stable (no glitch).
//   - No arithmetic; all fields pass through bit-exact.
// TESTING
//   1 Reset mid-SKID: fill both entries, pulse rst -> valid_w=0, ready_m=1, outputs 0 same cycle.
//   2 Streaming: valid_m=1, ready_w=1, ALUResultM=1,2,3.. each cycle -> ALUResultW=1,2,3..
//     one cycle later, ready_m never drops, no gaps.
//   3 Stall: send A=0x10,B=0x20 with ready_w=0 -> ready_m=0 after B; raise ready_w ->
//     W sees 0x10 then 0x20, C offered during stall only accepted once ready_m=1.
//   4 Flush in SKID with valid_m=1 -> next cycle valid_w=0, RegWriteW=0, ready_m=1;
//     the flushed-cycle input never appears on W.
//   5 Write qualifiers: RegWriteM=1,RdM=0 -> RegWriteW=0; RegWriteM=1,RdM=5 -> RegWriteW=1
//     only while valid_w=1.
//   6 SKID_EN=0 build: ready_w=0 with valid_w=1 -> ready_m=0 same cycle; ready_w=1 ->
//     ready_m=1 same cycle, back-to-back accept.

Source files
------------

// File: rtl/pipeline_mw_skid_if.sv
// MEM->WB handshake and payload bundle.
// master = memory stage plus writeback consumer; slave = the pipeline register.
interface pipeline_mw_skid_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_WIDTH   = 5,
  parameter int RSRC_WIDTH = 2
);
  logic                  flush;
  logic                  valid_m;
  logic                  ready_m;
  logic                  RegWriteM;
  logic [RSRC_WIDTH-1:0] ResultSrcM;
  logic [DATA_WIDTH-1:0] ALUResultM;
  logic [DATA_WIDTH-1:0] rd;
  logic [RD_WIDTH-1:0]   RdM;
  logic [DATA_WIDTH-1:0] PCPlus4M;
  logic                  valid_w;
  logic                  ready_w;
  logic                  RegWriteW;
  logic [RSRC_WIDTH-1:0] ResultSrcW;
  logic [DATA_WIDTH-1:0] ALUResultW;
  logic [DATA_WIDTH-1:0] ReadDataW;
  logic [RD_WIDTH-1:0]   RdW;
  logic [DATA_WIDTH-1:0] PCPlus4W;

  modport master (
    output flush, valid_m, RegWriteM, ResultSrcM, ALUResultM, rd, RdM, PCPlus4M, ready_w,
    input  ready_m, valid_w, RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W
  );

  modport slave (
    input  flush, valid_m, RegWriteM, ResultSrcM, ALUResultM, rd, RdM, PCPlus4M, ready_w,
    output ready_m, valid_w, RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W
  );
endinterface

// File: rtl/pipeline_mw_skid.sv
// MEM->WB pipeline register with valid/ready handshake, flush and optional 2-entry skid.
// Register writes are qualified so bubbles and x0 destinations never reach the register file.
module pipeline_mw_skid #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_WIDTH   = 5,
  parameter int RSRC_WIDTH = 2,
  parameter bit SKID_EN    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_mw_skid_if.slave bus
);

  localparam int PAY_W = RSRC_WIDTH + 3 * DATA_WIDTH + RD_WIDTH;

  // Encoding is {skid_valid, valid_w} so both handshake outputs come straight off flops.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b11
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               accept_s;
  logic               consume_s;
  logic               load_out_s;
  logic               load_skid_s;
  logic               skid_to_out_s;
  logic [PAY_W-1:0]   m_pay_s;
  logic [PAY_W-1:0]   out_pay_r;
  logic [PAY_W-1:0]   skid_pay_r;
  logic               m_regw_s;
  logic               out_regw_r;
  logic               out_regw_nxt_s;
  logic               skid_regw_r;

  assign m_pay_s  = {bus.ResultSrcM, bus.ALUResultM, bus.rd, bus.RdM, bus.PCPlus4M};
  assign m_regw_s = bus.RegWriteM & (|bus.RdM);

  assign accept_s  = bus.valid_m & bus.ready_m & ~bus.flush;
  assign consume_s = state_r[0] & bus.ready_w;

  generate
    if (SKID_EN) begin : g_skid_ready
      assign bus.ready_m = ~state_r[1];
    end else begin : g_comb_ready
      assign bus.ready_m = bus.ready_w | ~state_r[0];
    end
  endgenerate

  // Next-state and load strobes; flush wins over both accept and consume.
  always_comb begin
    state_nxt_s   = state_r;
    load_out_s    = 1'b0;
    load_skid_s   = 1'b0;
    skid_to_out_s = 1'b0;
    if (bus.flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nxt_s = ST_FULL;
            load_out_s  = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (accept_s && consume_s) begin
            state_nxt_s = ST_FULL;
            load_out_s  = 1'b1;
          end else if (accept_s) begin
            if (SKID_EN) begin
              state_nxt_s = ST_SKID;
              load_skid_s = 1'b1;
            end else begin
              // Unreachable without skid: ready_m implies ready_w once full.
              state_nxt_s = ST_FULL;
              load_out_s  = 1'b1;
            end
          end else if (consume_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        ST_SKID: begin
          if (consume_s) begin
            state_nxt_s   = ST_FULL;
            skid_to_out_s = 1'b1;
          end else begin
            state_nxt_s = ST_SKID;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Qualified write enable follows the entry into the output reg and drops with valid_w.
  always_comb begin
    out_regw_nxt_s = 1'b0;
    if (load_out_s) begin
      out_regw_nxt_s = m_regw_s;
    end else if (skid_to_out_s) begin
      out_regw_nxt_s = skid_regw_r;
    end else if (state_nxt_s != ST_EMPTY) begin
      out_regw_nxt_s = out_regw_r;
    end else begin
      out_regw_nxt_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output payload register; holds steady while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_pay_r  <= {PAY_W{1'b0}};
      out_regw_r <= 1'b0;
    end else begin
      out_regw_r <= out_regw_nxt_s;
      if (load_out_s) begin
        out_pay_r <= m_pay_s;
      end else if (skid_to_out_s) begin
        out_pay_r <= skid_pay_r;
      end else begin
        out_pay_r <= out_pay_r;
      end
    end
  end

  // Skid entry, captured only when the output reg is occupied and not draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_pay_r  <= {PAY_W{1'b0}};
      skid_regw_r <= 1'b0;
    end else if (load_skid_s) begin
      skid_pay_r  <= m_pay_s;
      skid_regw_r <= m_regw_s;
    end else begin
      skid_pay_r  <= skid_pay_r;
      skid_regw_r <= skid_regw_r;
    end
  end

  assign bus.valid_w   = state_r[0];
  assign bus.RegWriteW = out_regw_r;
  assign {bus.ResultSrcW, bus.ALUResultW, bus.ReadDataW, bus.RdW, bus.PCPlus4W} = out_pay_r;

endmodule

// File: tb/tb_pipeline_mw_skid.sv
// Bench for pipeline_mw_skid: skid and non-skid builds share stimulus, each checked
// against a queue-based FIFO model (capacity 2 with registered ready, or capacity 1).
module tb_pipeline_mw_skid;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int SW = 2;
  localparam int FW = SW + 3 * DW + RW;

  typedef struct packed {
    logic          regw;
    logic [SW-1:0] src;
    logic [DW-1:0] alu;
    logic [DW-1:0] rdat;
    logic [RW-1:0] rd;
    logic [DW-1:0] pc;
  } pay_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pay_t in_p;
  logic in_valid, in_ready, in_flush;

  pipeline_mw_skid_if #(.DATA_WIDTH(DW), .RD_WIDTH(RW), .RSRC_WIDTH(SW)) bus1 ();
  pipeline_mw_skid_if #(.DATA_WIDTH(DW), .RD_WIDTH(RW), .RSRC_WIDTH(SW)) bus0 ();

  pipeline_mw_skid #(.DATA_WIDTH(DW), .RD_WIDTH(RW), .RSRC_WIDTH(SW), .SKID_EN(1'b1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  pipeline_mw_skid #(.DATA_WIDTH(DW), .RD_WIDTH(RW), .RSRC_WIDTH(SW), .SKID_EN(1'b0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));

  assign bus1.flush = in_flush;     assign bus0.flush = in_flush;
  assign bus1.valid_m = in_valid;   assign bus0.valid_m = in_valid;
  assign bus1.ready_w = in_ready;   assign bus0.ready_w = in_ready;
  assign bus1.RegWriteM = in_p.regw; assign bus0.RegWriteM = in_p.regw;
  assign bus1.ResultSrcM = in_p.src; assign bus0.ResultSrcM = in_p.src;
  assign bus1.ALUResultM = in_p.alu; assign bus0.ALUResultM = in_p.alu;
  assign bus1.rd = in_p.rdat;       assign bus0.rd = in_p.rdat;
  assign bus1.RdM = in_p.rd;        assign bus0.RdM = in_p.rd;
  assign bus1.PCPlus4M = in_p.pc;   assign bus0.PCPlus4M = in_p.pc;

  logic [FW-1:0] got1, got0;
  assign got1 = {bus1.ResultSrcW, bus1.ALUResultW, bus1.ReadDataW, bus1.RdW, bus1.PCPlus4W};
  assign got0 = {bus0.ResultSrcW, bus0.ALUResultW, bus0.ReadDataW, bus0.RdW, bus0.PCPlus4W};

  pay_t q1[$];
  pay_t q0[$];
  int total = 0;
  int bad = 0;

  logic          e1_valid, e1_ready, e1_regw, e0_valid, e0_ready, e0_regw;
  logic [FW-1:0] e1_f, e0_f;

  function automatic logic [FW-1:0] fields(input pay_t p);
    return {p.src, p.alu, p.rdat, p.rd, p.pc};
  endfunction

  function automatic pay_t mk(input logic [DW-1:0] alu, input logic [RW-1:0] rd, input logic regw);
    pay_t p;
    p.regw = regw; p.src = alu[1:0]; p.alu = alu; p.rdat = ~alu; p.rd = rd; p.pc = alu + 32'd4;
    return p;
  endfunction

  function automatic pay_t rand_pay();
    pay_t p;
    p.regw = 1'($urandom_range(0, 1));
    p.src  = 2'($urandom_range(0, 3));
    p.alu  = $urandom; p.rdat = $urandom; p.pc = $urandom;
    p.rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    return p;
  endfunction

  // Drive this cycle's inputs and derive the expected outputs from the models.
  task automatic apply(input pay_t p, input logic v, input logic rw, input logic fl);
    in_p = p; in_valid = v; in_ready = rw; in_flush = fl;
    #1;
    e1_valid = (q1.size() > 0);
    e1_ready = (q1.size() < 2);
    e1_f     = e1_valid ? fields(q1[0]) : '0;
    e1_regw  = e1_valid && q1[0].regw && (q1[0].rd != 5'd0);
    e0_valid = (q0.size() > 0);
    e0_ready = rw || (q0.size() == 0);
    e0_f     = e0_valid ? fields(q0[0]) : '0;
    e0_regw  = e0_valid && q0[0].regw && (q0[0].rd != 5'd0);
  endtask

  // Clock edge: update both FIFO models from this cycle's handshakes.
  task automatic tick();
    logic a1, c1, a0, c0;
    a1 = in_valid && (q1.size() < 2) && !in_flush;
    c1 = (q1.size() > 0) && in_ready;
    a0 = in_valid && (in_ready || q0.size() == 0) && !in_flush;
    c0 = (q0.size() > 0) && in_ready;
    @(posedge clk);
    if (in_flush) begin
      q1.delete(); q0.delete();
    end else begin
      if (c1) void'(q1.pop_front());
      if (a1) q1.push_back(in_p);
      if (c0) void'(q0.pop_front());
      if (a0) q0.push_back(in_p);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) begin
      apply('0, 1'b0, 1'b1, 1'b0);
      tick();
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    total++;
    if ({bus1.valid_w, bus1.ready_m, bus1.RegWriteW} !== 3'b010 || got1 !== '0) begin
      bad++; $display("FAIL reset_skid got v/r/w=%b%b%b pay=%h want 010 pay=0", bus1.valid_w, bus1.ready_m, bus1.RegWriteW, got1);
    end
    total++;
    if ({bus0.valid_w, bus0.ready_m, bus0.RegWriteW} !== 3'b010 || got0 !== '0) begin
      bad++; $display("FAIL reset_noskid got v/r/w=%b%b%b pay=%h want 010 pay=0", bus0.valid_w, bus0.ready_m, bus0.RegWriteW, got0);
    end
    @(negedge clk);
    rst = 1'b0;
    q1.delete(); q0.delete();
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i++) begin
      apply(mk(32'(i), 5'(i), 1'b1), 1'b1, 1'b1, 1'b0);
      total++;
      if (bus1.ready_m !== 1'b1) begin bad++; $display("FAIL stream_ready i=%0d got %b want 1", i, bus1.ready_m); end
      if (i > 1) begin
        total++;
        if (bus1.valid_w !== 1'b1 || bus1.ALUResultW !== 32'(i - 1)) begin
          bad++; $display("FAIL stream_data i=%0d got v=%b alu=%0d want v=1 alu=%0d", i, bus1.valid_w, bus1.ALUResultW, i - 1);
        end
      end
      tick();
    end
    apply('0, 1'b0, 1'b1, 1'b0);
    total++;
    if (bus1.valid_w !== 1'b1 || bus1.ALUResultW !== 32'd8) begin
      bad++; $display("FAIL stream_last got v=%b alu=%0d want v=1 alu=8", bus1.valid_w, bus1.ALUResultW);
    end
    tick();
  endtask

  task automatic test_stall();
    apply(mk(32'h10, 5'd1, 1'b1), 1'b1, 1'b0, 1'b0); tick();
    apply(mk(32'h20, 5'd2, 1'b1), 1'b1, 1'b0, 1'b0);
    total++;
    if (bus1.ready_m !== 1'b1 || bus1.ALUResultW !== 32'h10) begin
      bad++; $display("FAIL stall_b got r=%b alu=%h want r=1 alu=10", bus1.ready_m, bus1.ALUResultW);
    end
    tick();
    apply(mk(32'h30, 5'd3, 1'b1), 1'b1, 1'b0, 1'b0);
    total++;
    if (bus1.ready_m !== 1'b0 || bus1.ALUResultW !== 32'h10) begin
      bad++; $display("FAIL stall_full got r=%b alu=%h want r=0 alu=10", bus1.ready_m, bus1.ALUResultW);
    end
    tick();
    apply(mk(32'h30, 5'd3, 1'b1), 1'b1, 1'b1, 1'b0);
    total++;
    if (bus1.ready_m !== 1'b0 || bus1.valid_w !== 1'b1 || bus1.ALUResultW !== 32'h10) begin
      bad++; $display("FAIL stall_release got r=%b v=%b alu=%h want r=0 v=1 alu=10", bus1.ready_m, bus1.valid_w, bus1.ALUResultW);
    end
    tick();
    apply(mk(32'h30, 5'd3, 1'b1), 1'b1, 1'b1, 1'b0);
    total++;
    if (bus1.ready_m !== 1'b1 || bus1.ALUResultW !== 32'h20) begin
      bad++; $display("FAIL stall_second got r=%b alu=%h want r=1 alu=20", bus1.ready_m, bus1.ALUResultW);
    end
    tick();
    apply('0, 1'b0, 1'b1, 1'b0);
    total++;
    if (bus1.valid_w !== 1'b1 || bus1.ALUResultW !== 32'h30) begin
      bad++; $display("FAIL stall_c got v=%b alu=%h want v=1 alu=30", bus1.valid_w, bus1.ALUResultW);
    end
    tick();
    apply('0, 1'b0, 1'b1, 1'b0);
    total++;
    if (bus1.valid_w !== 1'b0) begin bad++; $display("FAIL stall_empty got v=%b want 0", bus1.valid_w); end
    tick();
  endtask

  task automatic test_flush();
    apply(mk(32'h1, 5'd7, 1'b1), 1'b1, 1'b0, 1'b0); tick();
    apply(mk(32'h2, 5'd8, 1'b1), 1'b1, 1'b0, 1'b0); tick();
    apply(mk(32'hDEAD, 5'd9, 1'b1), 1'b1, 1'b1, 1'b1);
    total++;
    if (bus1.ready_m !== 1'b0 || bus1.valid_w !== 1'b1) begin
      bad++; $display("FAIL flush_pre got r=%b v=%b want r=0 v=1", bus1.ready_m, bus1.valid_w);
    end
    tick();
    apply('0, 1'b0, 1'b0, 1'b0);
    total++;
    if ({bus1.valid_w, bus1.RegWriteW, bus1.ready_m} !== 3'b001) begin
      bad++; $display("FAIL flush_skid got v/w/r=%b%b%b want 001", bus1.valid_w, bus1.RegWriteW, bus1.ready_m);
    end
    total++;
    if ({bus0.valid_w, bus0.RegWriteW} !== 2'b00) begin
      bad++; $display("FAIL flush_noskid got v/w=%b%b want 00", bus0.valid_w, bus0.RegWriteW);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      apply('0, 1'b0, 1'b1, 1'b0);
      total++;
      if (bus1.valid_w !== 1'b0 || bus0.valid_w !== 1'b0) begin
        bad++; $display("FAIL flush_drop i=%0d got v1=%b v0=%b want 0 0", i, bus1.valid_w, bus0.valid_w);
      end
      tick();
    end
  endtask

  task automatic test_qualifiers();
    apply(mk(32'h55, 5'd0, 1'b1), 1'b1, 1'b0, 1'b0); tick();
    apply('0, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus1.valid_w !== 1'b1 || bus1.RegWriteW !== 1'b0) begin
      bad++; $display("FAIL qual_x0 got v=%b w=%b want v=1 w=0", bus1.valid_w, bus1.RegWriteW);
    end
    apply(mk(32'h66, 5'd5, 1'b1), 1'b1, 1'b1, 1'b0); tick();
    apply('0, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus1.valid_w !== 1'b1 || bus1.RegWriteW !== 1'b1 || bus1.RdW !== 5'd5) begin
      bad++; $display("FAIL qual_rd5 got v=%b w=%b rd=%0d want v=1 w=1 rd=5", bus1.valid_w, bus1.RegWriteW, bus1.RdW);
    end
    tick();
    apply('0, 1'b0, 1'b1, 1'b0);
    total++;
    if (bus1.RegWriteW !== 1'b1) begin bad++; $display("FAIL qual_hold got w=%b want 1", bus1.RegWriteW); end
    tick();
    apply('0, 1'b0, 1'b1, 1'b0);
    total++;
    if (bus1.valid_w !== 1'b0 || bus1.RegWriteW !== 1'b0) begin
      bad++; $display("FAIL qual_bubble got v=%b w=%b want 0 0", bus1.valid_w, bus1.RegWriteW);
    end
    tick();
  endtask

  task automatic test_noskid();
    apply(mk(32'hA, 5'd1, 1'b1), 1'b1, 1'b0, 1'b0); tick();
    apply(mk(32'hB, 5'd2, 1'b1), 1'b1, 1'b0, 1'b0);
    total++;
    if (bus0.ready_m !== 1'b0 || bus0.valid_w !== 1'b1 || bus0.ALUResultW !== 32'hA) begin
      bad++; $display("FAIL noskid_stall got r=%b v=%b alu=%h want r=0 v=1 alu=a", bus0.ready_m, bus0.valid_w, bus0.ALUResultW);
    end
    apply(mk(32'hB, 5'd2, 1'b1), 1'b1, 1'b1, 1'b0);
    total++;
    if (bus0.ready_m !== 1'b1) begin bad++; $display("FAIL noskid_comb_ready got %b want 1", bus0.ready_m); end
    tick();
    apply(mk(32'hC, 5'd3, 1'b1), 1'b1, 1'b1, 1'b0);
    total++;
    if (bus0.ALUResultW !== 32'hB || bus0.ready_m !== 1'b1) begin
      bad++; $display("FAIL noskid_b2b got alu=%h r=%b want alu=b r=1", bus0.ALUResultW, bus0.ready_m);
    end
    tick();
    apply('0, 1'b0, 1'b1, 1'b0);
    total++;
    if (bus0.valid_w !== 1'b1 || bus0.ALUResultW !== 32'hC) begin
      bad++; $display("FAIL noskid_c got v=%b alu=%h want v=1 alu=c", bus0.valid_w, bus0.ALUResultW);
    end
    tick();
  endtask

  task automatic test_reset_mid_skid();
    apply(mk(32'h71, 5'd4, 1'b1), 1'b1, 1'b0, 1'b0); tick();
    apply(mk(32'h72, 5'd6, 1'b1), 1'b1, 1'b0, 1'b0); tick();
    apply('0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus1.valid_w, bus1.ready_m, bus1.RegWriteW} !== 3'b010 || got1 !== '0) begin
      bad++; $display("FAIL reset_mid got v/r/w=%b%b%b pay=%h want 010 pay=0", bus1.valid_w, bus1.ready_m, bus1.RegWriteW, got1);
    end
    @(negedge clk);
    rst = 1'b0;
    q1.delete(); q0.delete();
  endtask

  task automatic test_random();
    pay_t p;
    for (int n = 0; n < 400; n++) begin
      p = rand_pay();
      apply(p, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      total++;
      if ({bus1.valid_w, bus1.ready_m, bus1.RegWriteW} !== {e1_valid, e1_ready, e1_regw}) begin
        bad++; $display("FAIL rnd_hs1 n=%0d got v/r/w=%b%b%b want %b%b%b", n, bus1.valid_w, bus1.ready_m, bus1.RegWriteW, e1_valid, e1_ready, e1_regw);
      end
      if (e1_valid) begin
        total++;
        if (got1 !== e1_f) begin bad++; $display("FAIL rnd_pay1 n=%0d got %h want %h", n, got1, e1_f); end
      end
      total++;
      if ({bus0.valid_w, bus0.ready_m, bus0.RegWriteW} !== {e0_valid, e0_ready, e0_regw}) begin
        bad++; $display("FAIL rnd_hs0 n=%0d got v/r/w=%b%b%b want %b%b%b", n, bus0.valid_w, bus0.ready_m, bus0.RegWriteW, e0_valid, e0_ready, e0_regw);
      end
      if (e0_valid) begin
        total++;
        if (got0 !== e0_f) begin bad++; $display("FAIL rnd_pay0 n=%0d got %h want %h", n, got0, e0_f); end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    in_p = '0; in_valid = 1'b0; in_ready = 1'b0; in_flush = 1'b0;
    test_reset();
    test_streaming();
    test_stall();
    drain();
    test_flush();
    test_qualifiers();
    drain();
    test_noskid();
    drain();
    test_reset_mid_skid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
